poly_phase_ctrl: RTL and testbench

Parametrised control FSM for the polyphase FIR interpolator: accepts one input sample per `Data_RDY` strobe and produces `INTERP_L` output samples, one per coefficient phase. It sequences delay-line load, MAC/adder-tree pipeline fill and a valid/ready output handshake, and drives the coefficient-bank select. It sits between the input sample source, the 63-tap FIR datapath and the downstream output consumer. Relative to the previous controller it adds a generic factor and pipeline depth, downstream backpressure, a bypass mode, back-to-back sample acceptance and overrun detection.

---
 rtl/poly_pkg.sv | 23 ++
 rtl/poly_phase_cnt.sv | 40 ++++
 rtl/poly_phase_ctrl.sv | 134 +++++++++++++
 tb/tb_poly_phase_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polyphase interpolator/decimator controllers:
// state encoding, default geometry and a width helper.
package poly_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FILL  = 2'd2,
    ST_VALID = 2'd3
  } poly_state_e;

  localparam int DEF_INTERP_L   = 8;
  localparam int DEF_PIPE_DEPTH = 4;

  // Bits needed to index n values; never less than one so ports stay legal.
  function automatic int poly_clog2(input int n);
    int r;
    r = 0;
    for (int i = 1; i < n; i = i * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/poly_phase_cnt.sv
// Modulo-MODULUS phase counter with synchronous clear and enable; last_o flags
// the final phase. Shared by the interpolator and decimator controllers.
module poly_phase_cnt #(
  parameter int MODULUS = 8,
  parameter int CNT_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap on >= so a corrupted count can never run past the top phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q >= CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/poly_phase_ctrl.sv
// Polyphase FIR interpolator controller: one input sample per Data_RDY, INTERP_L
// outputs (one per coefficient phase) delivered over a valid/ready handshake.
module poly_phase_ctrl
  import poly_pkg::*;
#(
  parameter int INTERP_L   = DEF_INTERP_L,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int PHASE_W    = poly_clog2(INTERP_L)
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               Data_RDY,
  input  logic               bypass,
  input  logic               out_ready,
  input  logic               ovr_clr,
  output logic               FIR_en,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_rdy,
  output logic               last,
  output logic               busy,
  output logic               overrun,
  output logic               overrun_flag,
  output poly_state_e        state_dbg
);

  // Handshake: an output word moves when sample_rdy && out_ready at a rising
  // edge; sample_rdy, phase and last hold steady until that happens.

  localparam int               FILL_W    = poly_clog2(PIPE_DEPTH);
  localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(PIPE_DEPTH - 1);

  poly_state_e       state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              bypass_q, bypass_d;
  logic              ovr_q, ovr_flag_q;
  logic              cnt_clr, cnt_en, phase_last, drop, xfer;

  poly_phase_cnt #(
    .MODULUS(INTERP_L),
    .CNT_W  (PHASE_W)
  ) u_phase_cnt (
    .clk_i (CLOCK),
    .rst_ni(RESET_N),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (phase),
    .last_o(phase_last)
  );

  assign FIR_en       = (state_q == ST_LOAD);
  assign sample_rdy   = (state_q == ST_VALID);
  assign last         = sample_rdy & (phase_last | bypass_q);
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = ovr_q;
  assign overrun_flag = ovr_flag_q;
  assign state_dbg    = state_q;
  assign xfer         = sample_rdy & out_ready;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    bypass_d = bypass_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Data_RDY) begin
          state_d  = ST_LOAD;
          bypass_d = bypass;
          cnt_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        drop    = Data_RDY;
        state_d = ST_FILL;
        fill_d  = FILL_LOAD;
      end
      ST_FILL: begin
        drop = Data_RDY;
        if (fill_q == '0) begin
          state_d = ST_VALID;
        end else begin
          fill_d = fill_q - FILL_W'(1);
        end
      end
      ST_VALID: begin
        if (xfer && last) begin
          // A sample arriving exactly on the final handshake chains straight in.
          cnt_clr = 1'b1;
          if (Data_RDY) begin
            state_d  = ST_LOAD;
            bypass_d = bypass;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          drop = Data_RDY;
          if (xfer) begin
            cnt_en  = 1'b1;
            fill_d  = FILL_LOAD;
            state_d = ST_FILL;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      fill_q     <= '0;
      bypass_q   <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      bypass_q <= bypass_d;
      ovr_q    <= drop;
      // A new overrun outranks a clear in the same cycle.
      if (drop) begin
        ovr_flag_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_phase_ctrl.sv
// Directed bench for poly_phase_ctrl: cycle table for L=4/D=4, backpressure,
// chaining/bypass and reset sequences, plus a parameter sweep over L and D.
module tb_poly_phase_ctrl;
  import poly_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (L=4, D=4) ----------------
  logic        dr, bp, ordy, clr;
  logic        fe, sr, lt, bz, ov, ovf;
  logic [1:0]  ph;
  poly_state_e st;

  poly_phase_ctrl #(.INTERP_L(4), .PIPE_DEPTH(4)) u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .Data_RDY(dr), .bypass(bp), .out_ready(ordy),
    .ovr_clr(clr), .FIR_en(fe), .phase(ph), .sample_rdy(sr), .last(lt),
    .busy(bz), .overrun(ov), .overrun_flag(ovf), .state_dbg(st)
  );

  // ---------------- sweep DUTs ----------------
  function automatic int sw_l(input int g);
    case (g)
      0, 1:    return 1;
      2, 3:    return 2;
      default: return 5;
    endcase
  endfunction
  function automatic int sw_d(input int g);
    return (g % 2 == 1) ? 3 : 1;
  endfunction

  logic       sw_dr, sw_bp;
  logic       sw_rdy  [6];
  logic       sw_last [6];
  logic       sw_busy [6];
  logic [2:0] sw_phase[6];

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int L  = sw_l(g);
    localparam int D  = sw_d(g);
    localparam int PW = poly_clog2(L);
    logic          g_fe, g_ov, g_ovf;
    logic [PW-1:0] g_ph;
    poly_state_e   g_st;
    poly_phase_ctrl #(.INTERP_L(L), .PIPE_DEPTH(D)) u_sw (
      .CLOCK(clk), .RESET_N(rst_n), .Data_RDY(sw_dr), .bypass(sw_bp), .out_ready(1'b1),
      .ovr_clr(1'b0), .FIR_en(g_fe), .phase(g_ph), .sample_rdy(sw_rdy[g]),
      .last(sw_last[g]), .busy(sw_busy[g]), .overrun(g_ov), .overrun_flag(g_ovf),
      .state_dbg(g_st)
    );
    assign sw_phase[g] = 3'(g_ph);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packed view of the main DUT: {FIR_en, sample_rdy, last, busy, overrun, flag, phase}
  function automatic logic [7:0] dut_vec();
    return {fe, sr, lt, bz, ov, ovf, ph};
  endfunction

  function automatic logic [7:0] mk(input logic f, s, l, b, o, of, input int p);
    return {f, s, l, b, o, of, 2'(p)};
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, b, r, c);
    dr = d; bp = b; ordy = r; clr = c;
  endtask

  typedef struct {
    logic       dr, bp, ordy, clr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic d, b, r, c, input logic [7:0] e);
    vec_t v;
    v.dr = d; v.bp = b; v.ordy = r; v.clr = c; v.exp = e;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] e;
    int         nexp, n_out[6];

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    sw_dr = 1'b0;
    sw_bp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    chk("reset_state", 32'(st), 32'(ST_IDLE));

    // Cycle table, Data_RDY at row 0, out_ready high; overrun / clear / set-wins.
    //     dr bp or clr       fe sr lt bz ov of ph
    row(1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));  // 0  IDLE, accept
    row(0, 0, 1, 0, mk(1, 0, 0, 1, 0, 0, 0));  // 1  LOAD
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 0));  // 2  FILL
    row(0, 1, 1, 0, mk(0, 0, 0, 1, 0, 0, 0));  // 3  bypass toggled, ignored
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 0));  // 4
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 0));  // 5
    row(0, 0, 1, 0, mk(0, 1, 0, 1, 0, 0, 0));  // 6  VALID p0
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 1));  // 7  FILL p1
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 1));  // 8
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 1));  // 9
    row(1, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 1));  // 10 Data_RDY dropped
    row(0, 0, 1, 0, mk(0, 1, 0, 1, 1, 1, 1));  // 11 VALID p1, overrun pulse
    row(0, 1, 1, 0, mk(0, 0, 0, 1, 0, 1, 2));  // 12 FILL p2
    row(0, 0, 1, 1, mk(0, 0, 0, 1, 0, 1, 2));  // 13 clear flag
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 2));  // 14
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 2));  // 15
    row(0, 0, 1, 0, mk(0, 1, 0, 1, 0, 0, 2));  // 16 VALID p2
    row(1, 0, 1, 1, mk(0, 0, 0, 1, 0, 0, 3));  // 17 drop + clear together
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 1, 1, 3));  // 18 set wins
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 1, 3));  // 19
    row(0, 0, 1, 0, mk(0, 0, 0, 1, 0, 1, 3));  // 20
    row(0, 0, 1, 0, mk(0, 1, 1, 1, 0, 1, 3));  // 21 VALID p3 last
    row(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 1, 0));  // 22 IDLE
    foreach (tbl[i]) begin
      drive(tbl[i].dr, tbl[i].bp, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("tbl_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
      tick();
    end

    drive(0, 0, 1, 1);
    tick();

    // Backpressure on phase 0, then chained Data_RDY with bypass on last transfer.
    for (int c = 0; c < 34; c++) begin
      int p;
      drive(c == 0 || c == 25, c == 3 || c == 25, !(c >= 6 && c <= 9), 0);
      p = (c <= 10) ? 0 : (c <= 15) ? 1 : (c <= 20) ? 2 : (c <= 25) ? 3 : 0;
      e = mk(c == 1 || c == 26,
             c inside {6, 7, 8, 9, 10, 15, 20, 25, 31},
             c == 25 || c == 31,
             c >= 1 && c <= 31, 0, 0, p);
      chk($sformatf("bp_chain_c%0d", c), 32'(dut_vec()), 32'(e));
      tick();
    end

    // Asynchronous reset while filling phase 2, then a clean restart.
    for (int c = 0; c < 14; c++) begin
      drive(c == 0, 0, 1, 0);
      tick();
    end
    chk("pre_reset_phase", 32'(ph), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(dut_vec()), 32'h0);
    chk("async_reset_state", 32'(st), 32'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_outputs", 32'(dut_vec()), 32'h0);
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 0, 1, 0);
      e = mk(c == 1, c == 6, 0, c >= 1, 0, 0, 0);
      chk($sformatf("restart_c%0d", c), 32'(dut_vec()), 32'(e));
      tick();
    end
    drive(0, 0, 1, 0);
    repeat (25) tick();

    // Parameter sweep: output count, phase order, last and D+1 spacing.
    for (int b = 0; b < 2; b++) begin
      for (int g = 0; g < 6; g++) n_out[g] = 0;
      for (int c = 0; c < 31; c++) begin
        sw_dr = (c == 0);
        sw_bp = (c <= 1) ? b[0] : ~b[0];
        for (int g = 0; g < 6; g++) begin
          if (sw_rdy[g]) begin
            nexp = (b == 1) ? 1 : sw_l(g);
            chk($sformatf("sw_b%0d_g%0d_n%0d_time", b, g, n_out[g]), 32'(c),
                32'(2 + sw_d(g) + n_out[g] * (sw_d(g) + 1)));
            chk($sformatf("sw_b%0d_g%0d_n%0d_phase", b, g, n_out[g]), 32'(sw_phase[g]),
                32'((b == 1) ? 0 : n_out[g]));
            chk($sformatf("sw_b%0d_g%0d_n%0d_last", b, g, n_out[g]), 32'(sw_last[g]),
                32'(n_out[g] == nexp - 1));
            n_out[g]++;
          end
        end
        tick();
      end
      for (int g = 0; g < 6; g++) begin
        nexp = (b == 1) ? 1 : sw_l(g);
        chk($sformatf("sw_b%0d_g%0d_count", b, g), 32'(n_out[g]), 32'(nexp));
        chk($sformatf("sw_b%0d_g%0d_idle", b, g), 32'(sw_busy[g]), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
